// File: rtl/rr_mux_pkg.sv
// Shared constants and state type for the round-robin output multiplexer.
// No logic here. Imported by rr_mux.
package rr_mux_pkg;

    localparam int RR_MUX_N_MAX = 8;
    localparam int RR_MUX_W_MAX = 64;
    localparam int RR_MUX_CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester searched from ptr+1 upward, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the request vector.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        c         = 0;
        // Walk from the farthest candidate to the nearest so the nearest hit wins.
        for (int k = N; k >= 1; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) begin
                any       = 1'b1;
                grant_idx = IW'(c);
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// Round-robin N:1 mux into a one-entry output register; xfer_count enabled by RR_MUX_CNT_EN.
// Latency: 1 cycle from in_valid/in_ready handshake to out_valid.
// Backpressure: in_ready is held low while out_valid=1 and out_ready=0; drain and reload share a cycle.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*W-1:0]            in_data,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    output logic [W-1:0]              out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(N)-1:0]      out_sel,
    output logic [RR_MUX_CNT_W-1:0]   xfer_count
);

    localparam int IW = $clog2(N);

    rr_state_t     state, state_nxt;
    logic [IW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          any;
    logic          load;
    logic          take;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign out_valid = (state == ST_FULL);
    assign load      = !out_valid || out_ready;
    assign take      = load && any && !reset;
    assign in_ready  = take ? grant : '0;

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = any ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // ptr resets to N-1 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= IW'(N - 1);
        end else if (take) begin
            out_data <= in_data[grant_idx*W +: W];
            out_sel  <= grant_idx;
            ptr      <= grant_idx;
        end
    end

`ifdef RR_MUX_CNT_EN
    logic [RR_MUX_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (out_valid && out_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign xfer_count = cnt;
`else
    assign xfer_count = '0;
`endif

endmodule
